// File: rtl/cam_capture.sv
// cam_capture: locks onto the OV7670 parallel bus once camera configuration is
// done, packs RGB565 byte pairs into RGB444 pixels and writes them into the
// frame buffer at line*H_PIXELS + column. Everything runs on the camera PCLK.
//
// Write interface: wr_en is a one-cycle strobe with no backpressure. The frame
// buffer must accept a write on every cycle that wr_en is high. wr_addr and
// wr_data are valid while wr_en is high and hold their last values otherwise.
//
// ADDR_W must satisfy 2**ADDR_W >= H_PIXELS*V_LINES. Addresses never wrap
// because both counters saturate at their limits.
module cam_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              config_done,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              capturing,
  output logic              overrun,
  output logic [1:0]        dbg_state_o
);

  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cfg_s1_q, cfg_s2_q, cfg_ok_q;
  logic                vs_q, hr_q;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  // Start address of the current line. It steps by H_PIXELS on each line
  // change, so no multiplier is needed.
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                phase_q, phase_d;
  // Only the high-byte bits that reach the pixel are kept: {d[7:4], d[2:0]}.
  logic [6:0]          hi_q, hi_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]         wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;

  logic vs_fall, vs_rise, hr_fall;
  logic unused_d_bits;

  // RGB565 -> RGB444 keeps only the top bits of each colour channel.
  assign unused_d_bits = ^{d[6:5], d[0]};

  assign vs_fall = vs_q & ~vsync;
  assign vs_rise = ~vs_q & vsync;
  assign hr_fall = hr_q & ~href;

  // Two-flop synchroniser for config_done, then a sticky "configured" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_s1_q <= 1'b0;
      cfg_s2_q <= 1'b0;
      cfg_ok_q <= 1'b0;
    end else begin
      cfg_s1_q <= config_done;
      cfg_s2_q <= cfg_s1_q;
      cfg_ok_q <= cfg_ok_q | cfg_s2_q;
    end
  end

  // State, counters, edge-detect history and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      hr_q         <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      base_q       <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vsync;
      hr_q         <= href;
      col_q        <= col_d;
      line_q       <= line_d;
      base_q       <= base_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: frame sync, byte pairing, bounds checks and writes.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    base_d       = base_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      IDLE: begin
        if (cfg_ok_q) begin
          state_d = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        // Only a fresh frame start is captured, never a frame already running.
        if (vs_fall) begin
          state_d = CAPTURE;
          col_d   = '0;
          line_d  = '0;
          base_d  = '0;
          phase_d = 1'b0;
        end
      end

      CAPTURE: begin
        // A vsync rise wins over any byte presented in the same cycle.
        if (vs_rise) begin
          frame_done_d = 1'b1;
          state_d      = WAIT_FRAME;
        end else if (href) begin
          if (!phase_q) begin
            hi_d    = {d[7:4], d[2:0]};
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((col_q < COL_MAX) && (line_q < LINE_MAX)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_q + ADDR_W'(col_q);
              wr_data_d = {hi_q[6:3], hi_q[2:0], d[7], d[4:1]};
            end else begin
              overrun_d = 1'b1;
            end
            if (col_q < COL_MAX) begin
              col_d = col_q + COL_ONE;
            end
          end
        end else if (hr_fall) begin
          // End of line: any unpaired byte is dropped with the phase reset.
          col_d   = '0;
          phase_d = 1'b0;
          if (line_q < LINE_MAX) begin
            line_d = line_q + LINE_ONE;
            base_d = base_q + LINE_STEP;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign capturing   = (state_q == CAPTURE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Downstream of the camera configuration stage. Once `done_cam_config` has been seen, it locks onto the OV7670 parallel video bus (VSYNC/HREF/D[7:0]).
- Assembles byte pairs (RGB565, high byte first) into 12-bit RGB444 pixels.
- Writes each pixel to the frame buffer through a single-cycle write strobe with a linear address.
- Clocked by the camera pixel clock. The frame buffer's other port feeds the VGA side.

Parameters:
- H_PIXELS, 640, active pixels per line; columns beyond this are dropped.
- V_LINES, 480, active lines per frame; lines beyond this are dropped.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- clk  input  1  camera PCLK; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- config_done  input  1  `done_cam_config` from the configuration stage; asynchronous to clk.
- vsync  input  1  camera VSYNC; high = vertical blanking.
- href  input  1  camera HREF; high = valid bytes on d.
- d  input  8  camera data byte.
- wr_en  output  1  one-cycle frame-buffer write strobe.
- wr_addr  output  ADDR_W  write address = line*H_PIXELS + column.
- wr_data  output  12  pixel {R[3:0],G[3:0],B[3:0]}.
- frame_done  output  1  one-cycle pulse at the end of each captured frame.
- capturing  output  1  high while in the CAPTURE state.
- overrun  output  1  sticky; set when a line or column exceeds the limits.

Behaviour:
- Reset (rst low, asynchronous): all outputs and registers go to 0 and the state goes to IDLE. When rst is released, the block starts in IDLE.
- config_done handling:
  - Passes through a 2-FF synchroniser, then a sticky flag `cfg_ok`.
  - Deassertion of config_done after it has been seen is ignored.
- vsync and href are registered once, as vs_q and hr_q, for edge detection. The data byte d is sampled in the same cycle as href.
- FSM states:
  - IDLE: wait for cfg_ok = 1, then go to WAIT_FRAME.
  - WAIT_FRAME: wait for a vsync falling edge (vs_q = 1, vsync = 0). On that edge, clear the line and column counters and the byte phase, then go to CAPTURE.
  - CAPTURE: on a vsync rising edge, pulse frame_done for 1 cycle and return to WAIT_FRAME. A frame already in progress when cfg_ok rises is never captured.
- Byte assembly in CAPTURE, while href = 1:
  - phase 0: latch d into hi_byte, set phase to 1.
  - phase 1: form the pixel as R = hi[7:4], G = {hi[2:0], d[7]}, B = d[4:1]. Set phase to 0.
- Write timing:
  - wr_en goes high the cycle after the phase-1 byte is sampled (1-cycle latency).
  - wr_data and wr_addr are valid while wr_en = 1 and hold their values otherwise.
  - A write happens only if column < H_PIXELS and line < V_LINES. Otherwise the pixel is dropped and overrun is set.
  - The column counter increments after each assembled pixel.
- href falling edge (hr_q = 1, href = 0):
  - Line increments, column clears, phase clears.
  - A half pixel (odd byte count) is discarded without a write.
- Short lines and short frames:
  - A short line is legal; the next line still starts at line*H_PIXELS.
  - A frame with fewer than V_LINES lines still ends normally on the vsync rising edge.
- The line counter saturates at V_LINES. The column counter saturates at H_PIXELS. The address never wraps.
- Simultaneous vsync rise and href high: the vsync edge takes priority. The frame ends and the byte is ignored.
- href high while in WAIT_FRAME or IDLE is ignored.
- overrun clears only on reset.
- Reset mid-frame: everything clears immediately. The next capture starts at the next vsync falling edge after cfg_ok is set again. Because the synchroniser clears on reset, this requires 2 clk cycles with config_done high.

Test Plan:
- Ordering -> no capture: config_done low, toggle vsync/href with data -> wr_en never asserts, capturing = 0. Raise config_done -> capturing goes to 1 only after the next vsync falling edge.
- Single pixel conversion: a line with bytes 0xF8, 0x1F -> one write with wr_data = 0xF0F, wr_addr = 0. Bytes 0x07, 0xE0 -> wr_data = 0x0F0, wr_addr = 1.
- Full frame, 640x480, incrementing pattern:
  - Exactly 307200 writes.
  - Last wr_addr = 307199.
  - frame_done pulses once, on the cycle after vsync rises.
  - overrun = 0.
- Boundaries:
  - Line of 643 bytes -> 321 writes, the last byte is discarded, and the next line's first wr_addr = 640.
  - Line of 1282 bytes -> 640 writes and overrun = 1.
  - 481 lines -> line 480 is not written and overrun = 1.
- Edge cases:
  - vsync rises in the same cycle as an href-high byte -> frame_done pulses and no write occurs.
  - rst pulsed low mid-line -> outputs are 0 immediately, and capture restarts at the next frame boundary.
